// File: rtl/cmplx_mac_if.sv
// Sample/result bus for the complex MAC.
// The master drives samples and the slave returns accumulated dumps.
interface cmplx_mac_if #(
   parameter int AW = 16,
   parameter int BW = 14,
   parameter int PW = 48,
   parameter int LW = 8
);
   logic                 ce;
   logic                 valid;
   logic                 conj;
   logic signed [AW-1:0] ar;
   logic signed [AW-1:0] ai;
   logic signed [BW-1:0] br;
   logic signed [BW-1:0] bi;
   logic [LW-1:0]        acc_len;
   logic signed [PW-1:0] res_re;
   logic signed [PW-1:0] res_im;
   logic                 res_valid;

   modport master (
      output ce, valid, conj, ar, ai, br, bi, acc_len,
      input  res_re, res_im, res_valid
   );

   modport slave (
      input  ce, valid, conj, ar, ai, br, bi, acc_len,
      output res_re, res_im, res_valid
   );
endinterface

// File: rtl/cmplx_mac_pipe.sv
// Four-stage complex multiply (A*B or A*conj(B)) with windowed accumulate-and-dump.
// CE gates every register, so a stall freezes the pipeline and the output pulse.
module cmplx_mac_pipe #(
   parameter int AW = 16,
   parameter int BW = 14,
   parameter int PW = 48,
   parameter int LW = 8
) (
   input logic           clk,
   input logic           rst_n,
   cmplx_mac_if.slave    bus
);
   localparam int MW = AW + BW;
   localparam int SW = MW + 1;

   logic                 s1_valid, s1_conj;
   logic signed [AW-1:0] s1_ar, s1_ai;
   logic signed [BW-1:0] s1_br, s1_bi;
   logic [LW-1:0]        s1_len;

   logic                 s2_valid, s2_conj;
   logic signed [MW-1:0] s2_rr, s2_ii, s2_ir, s2_ri;
   logic [LW-1:0]        s2_len;

   logic                 s3_valid;
   logic signed [SW-1:0] s3_re, s3_im;
   logic [LW-1:0]        s3_len;

   logic [LW-1:0]        cnt, len;
   logic signed [PW-1:0] acc_re, acc_im;
   logic signed [PW-1:0] res_re, res_im;
   logic                 res_valid;

   logic signed [PW-1:0] prod_re, prod_im, sum_re, sum_im;
   logic [LW-1:0]        cur_len, cnt_next;
   logic                 dump;

   // A zero length is promoted to one here so later stages only ever see a usable length.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_conj  <= 1'b0;
         s1_ar    <= '0;
         s1_ai    <= '0;
         s1_br    <= '0;
         s1_bi    <= '0;
         s1_len   <= '0;
         s2_valid <= 1'b0;
         s2_conj  <= 1'b0;
         s2_rr    <= '0;
         s2_ii    <= '0;
         s2_ir    <= '0;
         s2_ri    <= '0;
         s2_len   <= '0;
         s3_valid <= 1'b0;
         s3_re    <= '0;
         s3_im    <= '0;
         s3_len   <= '0;
      end else if (bus.ce) begin
         s1_valid <= bus.valid;
         s1_conj  <= bus.conj;
         s1_ar    <= bus.ar;
         s1_ai    <= bus.ai;
         s1_br    <= bus.br;
         s1_bi    <= bus.bi;
         s1_len   <= (bus.acc_len == '0) ? LW'(1) : bus.acc_len;

         s2_valid <= s1_valid;
         s2_conj  <= s1_conj;
         s2_rr    <= MW'(s1_ar) * MW'(s1_br);
         s2_ii    <= MW'(s1_ai) * MW'(s1_bi);
         s2_ir    <= MW'(s1_ai) * MW'(s1_br);
         s2_ri    <= MW'(s1_ar) * MW'(s1_bi);
         s2_len   <= s1_len;

         s3_valid <= s2_valid;
         s3_len   <= s2_len;
         if (s2_conj) begin
            s3_re <= SW'(s2_rr) + SW'(s2_ii);
            s3_im <= SW'(s2_ir) - SW'(s2_ri);
         end else begin
            s3_re <= SW'(s2_rr) - SW'(s2_ii);
            s3_im <= SW'(s2_ir) + SW'(s2_ri);
         end
      end
   end

   // The first product of a window replaces the stale accumulator and brings its own length.
   always_comb begin
      prod_re = PW'(s3_re);
      prod_im = PW'(s3_im);
      if (cnt == '0) begin
         cur_len = s3_len;
         sum_re  = prod_re;
         sum_im  = prod_im;
      end else begin
         cur_len = len;
         sum_re  = acc_re + prod_re;
         sum_im  = acc_im + prod_im;
      end
      cnt_next = cnt + LW'(1);
      dump     = s3_valid && (cnt_next == cur_len);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         len       <= '0;
         acc_re    <= '0;
         acc_im    <= '0;
         res_re    <= '0;
         res_im    <= '0;
         res_valid <= 1'b0;
      end else if (bus.ce) begin
         res_valid <= dump;
         if (s3_valid) begin
            acc_re <= sum_re;
            acc_im <= sum_im;
            cnt    <= dump ? '0 : cnt_next;
            if (cnt == '0) begin
               len <= s3_len;
            end
         end
         if (dump) begin
            res_re <= sum_re;
            res_im <= sum_im;
         end
      end
   end

   assign bus.res_re    = res_re;
   assign bus.res_im    = res_im;
   assign bus.res_valid = res_valid;
endmodule

// File: tb/tb_cmplx_mac_pipe.sv
// Scoreboard bench for cmplx_mac_pipe: a behavioural window model queues expected dumps
// tagged with the enabled edge on which they must appear.
module tb_cmplx_mac_pipe;
   localparam int AW = 16;
   localparam int BW = 14;
   localparam int PW = 48;
   localparam int LW = 8;

   typedef struct {
      longint re;
      longint im;
      int     edge_idx;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   cmplx_mac_if #(.AW(AW), .BW(BW), .PW(PW), .LW(LW)) bus ();

   cmplx_mac_pipe #(.AW(AW), .BW(BW), .PW(PW), .LW(LW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   exp_t                 sb_queue[$];
   int                   en_edges = 0;
   int                   checks   = 0;
   int                   failures = 0;
   int                   m_cnt    = 0;
   int                   m_len    = 1;
   logic signed [PW-1:0] m_acc_re = '0;
   logic signed [PW-1:0] m_acc_im = '0;
   bit                   due;
   exp_t                 exp_item;

   task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                              input logic signed [63:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
      end
   endtask

   // Reference behaviour of one accepted sample, evaluated on the driven bus values.
   task automatic modelStep();
      longint rr, ii, ir, ri, p_re, p_im;
      int     req_len;
      exp_t   item;
      rr = longint'(bus.ar) * longint'(bus.br);
      ii = longint'(bus.ai) * longint'(bus.bi);
      ir = longint'(bus.ai) * longint'(bus.br);
      ri = longint'(bus.ar) * longint'(bus.bi);
      p_re = bus.conj ? rr + ii : rr - ii;
      p_im = bus.conj ? ir - ri : ir + ri;
      req_len = int'(bus.acc_len);
      if (m_cnt == 0) begin
         m_len    = (req_len == 0) ? 1 : req_len;
         m_acc_re = PW'(p_re);
         m_acc_im = PW'(p_im);
      end else begin
         m_acc_re = m_acc_re + PW'(p_re);
         m_acc_im = m_acc_im + PW'(p_im);
      end
      m_cnt++;
      if (m_cnt == m_len) begin
         item.re       = longint'(m_acc_re);
         item.im       = longint'(m_acc_im);
         item.edge_idx = en_edges + 4;
         sb_queue.push_back(item);
         m_cnt = 0;
      end
   endtask

   task automatic applyStimulus(input bit ce, input bit valid, input bit conj,
                                input int ar, input int ai, input int br, input int bi,
                                input int len);
      bus.ce      = ce;
      bus.valid   = valid;
      bus.conj    = conj;
      bus.ar      = ar[AW-1:0];
      bus.ai      = ai[AW-1:0];
      bus.br      = br[BW-1:0];
      bus.bi      = bi[BW-1:0];
      bus.acc_len = len[LW-1:0];
      if (ce && valid) modelStep();
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 1);
   endtask

   always @(posedge clk) begin
      if (rst_n === 1'b1 && bus.ce === 1'b1) en_edges <= en_edges + 1;
   end

   // A result is consumed at a negedge where CE is high; each enabled-edge index is visited once.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.ce === 1'b1) begin
         due = (sb_queue.size() > 0) && (sb_queue[0].edge_idx == en_edges);
         checkOutput("res_valid", bus.res_valid, due);
         if (due) begin
            exp_item = sb_queue.pop_front();
            if (bus.res_valid === 1'b1) begin
               checkOutput("res_re", bus.res_re, exp_item.re);
               checkOutput("res_im", bus.res_im, exp_item.im);
            end
         end
      end
   end

   initial begin
      rst_n       = 1'b0;
      bus.ce      = 1'b1;
      bus.valid   = 1'b0;
      bus.conj    = 1'b0;
      bus.ar      = '0;
      bus.ai      = '0;
      bus.br      = '0;
      bus.bi      = '0;
      bus.acc_len = 8'd1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_valid", bus.res_valid, 0);
      checkOutput("reset_re", bus.res_re, 0);
      checkOutput("reset_im", bus.res_im, 0);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      applyStimulus(1, 1, 0, 3, 4, 2, -1, 1);
      idleCycles(6);
      applyStimulus(1, 1, 1, 3, 4, 2, -1, 1);
      idleCycles(4);
      for (int i = 0; i < 6; i++) applyStimulus(1, 1, i[0], 3, 4, 2, -1, 1);
      idleCycles(4);

      applyStimulus(1, 1, 0, -32768, -32768, -8192, 8192, 1);
      applyStimulus(1, 1, 1, -32768, -32768, -8192, 8192, 1);
      applyStimulus(1, 1, 0, -32768, 32767, -8192, -8192, 1);
      idleCycles(5);

      for (int i = 0; i < 8; i++) applyStimulus(1, 1, 0, 3, 4, 2, -1, 4);
      idleCycles(5);
      for (int i = 0; i < 8; i++) applyStimulus(1, 1, 0, 3, 4, 2, -1, (i == 0) ? 4 : 2);
      idleCycles(5);

      // Stalls both mid-window and right as a dump pulse is on the output.
      for (int i = 0; i < 16; i++) begin
         applyStimulus(!(i inside {3, 4, 5, 10, 11, 12}), 1, 0, 3, 4, 2, -1, 4);
      end
      idleCycles(1);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
      idleCycles(5);

      applyStimulus(1, 1, 0, 5, -2, 7, 3, 4);
      applyStimulus(1, 1, 1, 5, -2, 7, 3, 4);
      idleCycles(3);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_rst_valid", bus.res_valid, 0);
      checkOutput("async_rst_re", bus.res_re, 0);
      checkOutput("async_rst_im", bus.res_im, 0);
      sb_queue.delete();
      m_cnt = 0;
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 1, 0, 1, 0, 4);
      idleCycles(6);

      for (int i = 0; i < 80; i++) begin
         applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                       $urandom_range(0, 1) == 1,
                       int'($urandom_range(0, 65535)) - 32768,
                       int'($urandom_range(0, 65535)) - 32768,
                       int'($urandom_range(0, 16383)) - 8192,
                       int'($urandom_range(0, 16383)) - 8192,
                       int'($urandom_range(0, 5)));
      end
      idleCycles(10);

      checkOutput("drain", sb_queue.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end
endmodule
